// File: rtl/grant_pkg.sv
// Shared types and helpers for the grant decoder.
package grant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_e;

    function automatic int outs_of(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/grant_decoder_bin_to_onehot.sv
// Combinational binary index to one-hot vector decoder.
module bin_to_onehot
    import grant_pkg::*;
#(
    parameter int IDX_W = 2,
    localparam int OUTS = outs_of(IDX_W)
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [OUTS-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/grant_decoder.sv
// Registered one-hot grant decoder with completion/timeout release and a cooldown cycle.
//
//   state | meaning
//   IDLE  | ready; the next valid index is captured and granted on the following cycle
//   GRANT | one-hot grant held until done[sel] or timeout
//   COOL  | single all-zero cycle before accepting again (break-before-make)
module grant_decoder
    import grant_pkg::*;
#(
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    localparam int OUTS   = outs_of(IDX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    output logic [OUTS-1:0]  grant,
    output logic             grant_valid,
    input  logic [OUTS-1:0]  done,
    output logic             timeout_err
);

    localparam int TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TLIM);

    state_e            state_q, state_d;
    logic [OUTS-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic [OUTS-1:0]   onehot;
    logic              sel_done;

    bin_to_onehot #(.IDX_W(IDX_W)) u_dec (
        .idx_i    (in_idx),
        .onehot_o (onehot)
    );

    // grant_q is one-hot while in GRANT, so masking done with it selects done[sel]
    assign sel_done = |(done & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = GRANT;
                    grant_d = onehot;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (sel_done) begin
                    state_d = COOL;
                    grant_d = '0;
                end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
                    state_d = COOL;
                    grant_d = '0;
                    terr_d  = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COOL: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: vector table plus hand-written corner sequences.
module tb_grant_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_idx;
    logic       in_ready;
    logic [3:0] grant;
    logic       grant_valid;
    logic [3:0] done;
    logic       timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic [3:0] dn;
        logic [3:0] g;
        logic       rdy;
        logic       terr;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic       rdy;
        logic       terr;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[6];

    grant_decoder #(.IDX_W(2), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_idx      (in_idx),
        .in_ready    (in_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!$onehot0(grant))
            $display("FAIL onehot0: grant=%b has more than one bit set", grant);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.name, ".grant"}, 32'(grant), 32'(e.g));
        chk({e.name, ".grant_valid"}, 32'(grant_valid), 32'(|e.g));
        chk({e.name, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
        chk({e.name, ".timeout_err"}, 32'(timeout_err), 32'(e.terr));
    endtask

    // Drive inputs for one cycle, queue the expected post-edge outputs, then compare.
    task automatic step(input string name, input logic v, input logic [1:0] idx,
                        input logic [3:0] dn, input logic [3:0] g, input logic rdy,
                        input logic terr);
        exp_t e;
        in_valid = v;
        in_idx   = idx;
        done     = dn;
        e.g = g; e.rdy = rdy; e.terr = terr; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_outputs(e);
        end
    endtask

    initial begin
        exp_t r;
        tbl[0] = '{v:1'b1, idx:2'd2, dn:4'b0000, g:4'b0100, rdy:1'b0, terr:1'b0};
        tbl[1] = '{v:1'b0, idx:2'd0, dn:4'b0000, g:4'b0100, rdy:1'b0, terr:1'b0};
        tbl[2] = '{v:1'b1, idx:2'd1, dn:4'b0000, g:4'b0100, rdy:1'b0, terr:1'b0};
        tbl[3] = '{v:1'b0, idx:2'd0, dn:4'b1011, g:4'b0100, rdy:1'b0, terr:1'b0};
        tbl[4] = '{v:1'b0, idx:2'd0, dn:4'b0100, g:4'b0000, rdy:1'b0, terr:1'b0};
        tbl[5] = '{v:1'b0, idx:2'd0, dn:4'b0000, g:4'b0000, rdy:1'b1, terr:1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; done = '0;
        repeat (2) @(posedge clk);
        #1;
        r.g = 4'b0000; r.rdy = 1'b1; r.terr = 1'b0; r.name = "reset";
        check_outputs(r);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Grant idx 2, release via done on the fourth visible cycle
        for (int i = 0; i < 6; i++)
            step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].idx, tbl[i].dn,
                 tbl[i].g, tbl[i].rdy, tbl[i].terr);

        // Timeout: only non-selected done bits asserted
        step("to_acc", 1'b1, 2'd1, 4'b1101, 4'b0010, 1'b0, 1'b0);
        for (int i = 1; i < 15; i++)
            step($sformatf("to_hold%0d", i), 1'b0, 2'd0, 4'b1101, 4'b0010, 1'b0, 1'b0);
        step("to_rel", 1'b0, 2'd0, 4'b1101, 4'b0000, 1'b0, 1'b1);
        step("to_idle", 1'b0, 2'd0, 4'b1101, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step($sformatf("to_stay%0d", i), 1'b0, 2'd0, 4'b1101, 4'b0000, 1'b1, 1'b0);

        // done coinciding with the last allowed cycle wins over the timeout
        step("last_acc", 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b0, 1'b0);
        for (int i = 1; i < 15; i++)
            step($sformatf("last_hold%0d", i), 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step("last_done", 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step("last_idle", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // Continuous valid: idx dropped during GRANT/COOL, one all-zero gap, done on first cycle
        step("b2b_acc3", 1'b1, 2'd3, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step("b2b_done3", 1'b1, 2'd0, 4'b1000, 4'b0000, 1'b0, 1'b0);
        step("b2b_cool", 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step("b2b_acc1", 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b0, 1'b0);
        step("b2b_done1", 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0, 1'b0);
        step("b2b_idle", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // Asynchronous reset while granting idx 3
        step("rst_acc", 1'b1, 2'd3, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step("rst_hold", 1'b0, 2'd0, 4'b0000, 4'b1000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        r.g = 4'b0000; r.rdy = 1'b1; r.terr = 1'b0; r.name = "rst_async";
        check_outputs(r);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step("rst_after", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step("rst_regrant", 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
